// File: rtl/coolgirl_serial_bank_ctrl.sv
// ---------------------------------------------------------------------------
// coolgirl_serial_bank_ctrl
//
// Serial-load bank controller for the multicart PRG/CHR mapping datapath.
// CPU writes to $8000-$FFFF are decoded as a 5-bit serial register protocol.
// The protocol feeds four 5-bit configuration registers: control, CHR0, CHR1
// and PRG. The mapped PRG bank, mapped CHR bank, CIRAM A10 and the PRG-RAM
// enable are decoded combinationally from those registers and the current
// CPU/PPU address bits.
//
// Parameters
//   IGNORE_CONSECUTIVE : 1 = a data write on the edge right after another
//                        write is dropped. Reset-bit writes are never dropped.
//   PRG_FIXED_LAST     : bank returned for the fixed upper window in PRG mode 3
//
// Ports
//   m2            in   CPU M2 clock; all state updates on its rising edge
//   reset_n       in   asynchronous active-low reset
//   romsel        in   low = $8000-$FFFF decoded
//   cpu_rw_in     in   low = write
//   cpu_addr_in   in   [1] = CPU A14 (PRG window), [0] = CPU A13
//   cpu_data_in   in   CPU data; bit 7 = reset bit, bit 0 = serial data
//   ppu_addr_in   in   [2] = PPU A12, [1] = PPU A11, [0] = PPU A10
//   prg_bank      out  mapped PRG 16K bank
//   chr_bank      out  mapped CHR 4K bank
//   ppu_ciram_a10 out  nametable select
//   sram_enabled  out  PRG-RAM enable
//   sr_count      out  serial bits collected so far (0-4)
// ---------------------------------------------------------------------------
module coolgirl_serial_bank_ctrl #(
  parameter bit         IGNORE_CONSECUTIVE = 1'b1,
  parameter logic [3:0] PRG_FIXED_LAST     = 4'hF
) (
  input  logic       m2,
  input  logic       reset_n,
  input  logic       romsel,
  input  logic       cpu_rw_in,
  input  logic [1:0] cpu_addr_in,
  input  logic [7:0] cpu_data_in,
  input  logic [2:0] ppu_addr_in,
  output logic [3:0] prg_bank,
  output logic [4:0] chr_bank,
  output logic       ppu_ciram_a10,
  output logic       sram_enabled,
  output logic [2:0] sr_count
);

  // The load machine has a single state, COLLECT. The bit count is its only
  // real state, and it returns to 0 on a load or on a reset bit.
  localparam logic [0:0] ST_COLLECT    = 1'b0;
  localparam logic [4:0] CONTROL_RESET = 5'b01100;
  localparam logic [2:0] COUNT_LAST    = 3'd4;

  localparam int CFG_CONTROL = 0;
  localparam int CFG_CHR0    = 1;
  localparam int CFG_CHR1    = 2;
  localparam int CFG_PRG     = 3;

  // Collected bits. The first bit received ends up in sr_reg[0] by the time
  // the fifth arrives, so it becomes bit 0 of the loaded value. The fifth
  // bit is taken directly from the bus, so only four bits are ever stored.
  logic [3:0] sr_reg, sr_next;
  logic [2:0] count_reg, count_next;
  logic       prev_wr_reg;
  logic [0:0] state_reg;

  logic       wr_event;
  logic       reset_bit;
  logic       wr_accept;
  logic       data_wr;
  logic       load_en;
  logic [4:0] load_value;

  logic [4:0] cfg_q [4];
  logic [4:0] control;
  logic [4:0] chr0;
  logic [4:0] chr1;
  logic [4:0] prg;

  // Only data bits 7 and 0 take part in the protocol.
  logic unused_data;
  assign unused_data = ^cpu_data_in[6:1];

  // ------------------------------------------------------------------------
  // Write qualification
  // ------------------------------------------------------------------------
  always_comb begin
    wr_event   = ~romsel & ~cpu_rw_in;
    reset_bit  = wr_event & cpu_data_in[7];
    // A reset bit is never filtered by the consecutive-write rule.
    wr_accept  = wr_event & (cpu_data_in[7] | ~(IGNORE_CONSECUTIVE & prev_wr_reg));
    data_wr    = wr_accept & ~cpu_data_in[7];
    load_en    = data_wr & (count_reg == COUNT_LAST);
    load_value = {cpu_data_in[0], sr_reg};
  end

  // ------------------------------------------------------------------------
  // Serial shift / count next-state
  // ------------------------------------------------------------------------
  always_comb begin
    sr_next    = sr_reg;
    count_next = count_reg;
    if (reset_bit || load_en) begin
      sr_next    = '0;
      count_next = '0;
    end else if (data_wr) begin
      sr_next    = {cpu_data_in[0], sr_reg[3:1]};
      count_next = count_reg + 3'd1;
    end
  end

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      sr_reg      <= '0;
      count_reg   <= '0;
      prev_wr_reg <= 1'b0;
      state_reg   <= ST_COLLECT;
    end else begin
      sr_reg      <= sr_next;
      count_reg   <= count_next;
      // Records every write event, including discarded ones, so a run of
      // adjacent writes keeps being filtered.
      prev_wr_reg <= wr_event;
      state_reg   <= ST_COLLECT;
    end
  end

  // ------------------------------------------------------------------------
  // Configuration registers: one instance per A14:A13 target.
  // ------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      localparam logic [1:0] SEL        = 2'(gi);
      localparam bit         IS_CONTROL = (gi == CFG_CONTROL);
      localparam logic [4:0] RST_VAL    = IS_CONTROL ? CONTROL_RESET : 5'd0;

      logic [4:0] q_reg;

      always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
          q_reg <= RST_VAL;
        end else if (IS_CONTROL && reset_bit) begin
          // A reset bit forces PRG mode 3 and leaves the other control bits.
          q_reg <= q_reg | CONTROL_RESET;
        end else if (load_en && (cpu_addr_in == SEL)) begin
          q_reg <= load_value;
        end
      end

      assign cfg_q[gi] = q_reg;
    end
  endgenerate

  assign control = cfg_q[CFG_CONTROL];
  assign chr0    = cfg_q[CFG_CHR0];
  assign chr1    = cfg_q[CFG_CHR1];
  assign prg     = cfg_q[CFG_PRG];

  // ------------------------------------------------------------------------
  // Combinational bank / mirroring decode
  // ------------------------------------------------------------------------
  always_comb begin
    prg_bank = {prg[3:1], cpu_addr_in[1]};
    unique case (control[3:2])
      2'd2:    prg_bank = cpu_addr_in[1] ? prg[3:0] : 4'd0;
      2'd3:    prg_bank = cpu_addr_in[1] ? PRG_FIXED_LAST : prg[3:0];
      default: prg_bank = {prg[3:1], cpu_addr_in[1]};
    endcase
  end

  always_comb begin
    if (control[4]) begin
      chr_bank = ppu_addr_in[2] ? chr1 : chr0;
    end else begin
      chr_bank = {chr0[4:1], ppu_addr_in[2]};
    end
  end

  always_comb begin
    ppu_ciram_a10 = 1'b0;
    unique case (control[1:0])
      2'd0:    ppu_ciram_a10 = 1'b0;
      2'd1:    ppu_ciram_a10 = 1'b1;
      2'd2:    ppu_ciram_a10 = ppu_addr_in[0];
      default: ppu_ciram_a10 = ppu_addr_in[1];
    endcase
  end

  assign sram_enabled = ~prg[4];
  assign sr_count     = count_reg;

  logic unused_state;
  assign unused_state = ^state_reg;

endmodule

// File: doc/coolgirl_serial_bank_ctrl.md
# coolgirl_serial_bank_ctrl

Serial-load bank controller for the multicart's PRG/CHR mapping datapath. It decodes CPU writes to $8000–$FFFF as a 5-bit serial register protocol and holds four internal configuration registers (control, CHR0, CHR1, PRG). From these it produces the mapped PRG bank, mapped CHR bank, CIRAM A10 and the SRAM enable. Its outputs feed the top-level PRG/CHR base/mask address logic in place of a parallel-register mapper.

## Interface
- IGNORE_CONSECUTIVE, default 1: when 1, a write on the edge directly after another write is discarded, except reset-bit writes.
- PRG_FIXED_LAST, default 4'hF: bank returned for the fixed upper window in PRG mode 3.
- m2  in  1  CPU M2 clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- romsel  in  1  low = $8000–$FFFF decoded.
- cpu_rw_in  in  1  low = write.
- cpu_addr_in  in  2  CPU A14:A13; selects the target register and the PRG window.
- cpu_data_in  in  8  CPU data; only bits 7 and 0 are used.
- ppu_addr_in  in  3  PPU A12:A10.
- prg_bank  out  4  mapped PRG 16K bank (maps to prg_addr_mapped[17:14]).
- chr_bank  out  5  mapped CHR 4K bank (maps to ppu_addr_mapped[16:12]).
- ppu_ciram_a10  out  1  nametable select.
- sram_enabled  out  1  PRG-RAM enable.
- sr_count  out  3  serial bits collected so far (0–4), for debug.

## Operation
- Write event: romsel=0 and cpu_rw_in=0 at a rising m2 edge.
- prev_wr: a 1-bit flag registered on every edge, holding this edge's write-event value.
- Consecutive rule: a write event with prev_wr=1 and IGNORE_CONSECUTIVE=1 is discarded, unless cpu_data_in[7]=1.
- Reset-bit write (data[7]=1):
  - sr ← 0, count ← 0.
  - control ← control | 5'b01100. Other registers are unchanged.
- Data write (data[7]=0):
  - sr ← {data[0], sr[4:1]}, count ← count+1.
  - On the write where count==4: value = {data[0], sr[4:1]} is loaded into the register selected by that write's A14:A13.
  - Selection: 0 = control, 1 = CHR0, 2 = CHR1, 3 = PRG.
  - After the load, sr ← 0 and count ← 0.
- Load state machine: COLLECT (count 0–4) only. It returns to count 0 on a load or on a reset bit.
- PRG decode, by control[3:2]:
  - 0 or 1: prg_bank = {prg[3:1], A14}.
  - 2: A14=0 → 0; A14=1 → prg[3:0].
  - 3: A14=0 → prg[3:0]; A14=1 → PRG_FIXED_LAST.
- CHR decode:
  - control[4]=0: chr_bank = {chr0[4:1], A12}.
  - control[4]=1: chr_bank = A12 ? chr1 : chr0.
- Mirroring, by control[1:0]: 0 → 0; 1 → 1; 2 → PPU A10; 3 → PPU A11.
- sram_enabled = ~prg[4].
- Reset values: sr=0, count=0, prev_wr=0, control=5'b01100, chr0=0, chr1=0, prg=0.
  - Resulting outputs at reset: prg_bank=0 for A14=0 and PRG_FIXED_LAST for A14=1; chr_bank={0000,A12}; ppu_ciram_a10=0; sram_enabled=1; sr_count=0.
- Reset asserted mid-sequence: partial sr/count are lost immediately. It must not produce a register load.

## Timing
- Serial state, registers and prev_wr change only on the rising m2 edge, or asynchronously on reset_n falling.
- Register load latency: the new value is visible on the outputs right after the edge of the 5th accepted write.
- Bank, mirroring and SRAM outputs are combinational from the registers and the current cpu_addr_in/ppu_addr_in: zero-cycle decode, no registering.
- A write on the first edge after reset_n deasserts is accepted, since prev_wr=0.
- A reset bit on the same edge as a would-be 5th write: the reset bit wins and no load occurs.
- A discarded write still sets prev_wr=1. A following third consecutive write is therefore also discarded.
- count never exceeds 4. There is no wrap or overflow path.

## Test plan
- After reset_n pulse: A14=1 → prg_bank=4'hF; A14=0 → prg_bank=0; sram_enabled=1; ppu_ciram_a10=0.
- Five non-consecutive writes to $E000 with data[0]=1,0,1,0,0 → prg=5'b00101. Then prg_bank=5 at A14=0 and 4'hF at A14=1. sr_count returns to 0.
- Five writes to $8000 with bits 0,1,0,0,0, then PPU A11 toggled → control=5'b00010; ppu_ciram_a10 follows PPU A10, not A11. Next, control=5'b10011 → CHR 4K mode and horizontal mirroring.
- Three writes, then a write with data=8'h80 → sr_count=0 and control[3:2]=3. Five more writes then load normally.
- Back-to-back writes on adjacent edges with IGNORE_CONSECUTIVE=1 → the second is dropped (sr_count advances by 1 only). With IGNORE_CONSECUTIVE=0 → sr_count advances by 2.
- Four writes followed by reset_n low for 1 ns → all registers return to reset values and no load is observed.
